// File: rtl/video_scanout.sv
// Video scan-out: free-running raster counters, 4x-scaled 512x480 image
// window fetched from VRAM, and a two-stage pipeline so that sync, display
// enable, pixel colour and frame_start all leave the block aligned with the
// memory read data.
// Visible area and sync positions are parameters whose defaults give the
// standard 640x480 timing.
module video_scanout #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int X_OFF        = 64,
  parameter int H_VIS        = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_VIS        = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492
) (
  input  logic        vclk,
  input  logic        rst_n,
  input  logic        blank,
  output logic [13:0] vaddr,
  input  logic [15:0] vout,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VISL = HW'(H_VIS);
  localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START);
  localparam logic [HW-1:0] H_SE   = HW'(H_SYNC_END);
  localparam logic [VW-1:0] V_VISL = VW'(V_VIS);
  localparam logic [VW-1:0] V_SS   = VW'(V_SYNC_START);
  localparam logic [VW-1:0] V_SE   = VW'(V_SYNC_END);
  localparam logic [HW-1:0] X_LO   = HW'(X_OFF);
  localparam logic [HW-1:0] X_HI   = HW'(X_OFF + 512);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // stage 0 decode (counter registers only)
  logic        vis0, hs0, vs0, win0, fs0;
  logic [15:0] h_rel, v_ext;

  // stage 1 flags, travelling alongside the VRAM read
  logic vis1, hs1, vs1, win1, fs1, blank1;

  // Raster counters: h wraps every line, v wraps after the last line.
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Stage 0: region decode and VRAM address from the counters.
  always_comb begin
    vis0  = (h_cnt < H_VISL) && (v_cnt < V_VISL);
    hs0   = !((h_cnt >= H_SS) && (h_cnt < H_SE));
    vs0   = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    win0  = (h_cnt >= X_LO) && (h_cnt < X_HI) && (v_cnt < V_VISL);
    fs0   = (h_cnt == '0) && (v_cnt == '0);
    h_rel = 16'(h_cnt) - 16'(X_OFF);
    v_ext = 16'(v_cnt);
    vaddr = win0 ? {v_ext[8:2], h_rel[8:2]} : 14'd0;
  end

  // Stage 1: delay the flags while memory returns data; blank is sampled here.
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      vis1   <= 1'b0;
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      win1   <= 1'b0;
      fs1    <= 1'b0;
      blank1 <= 1'b0;
    end else begin
      vis1   <= vis0;
      hs1    <= hs0;
      vs1    <= vs0;
      win1   <= win0;
      fs1    <= fs0;
      blank1 <= blank;
    end
  end

  // Stage 2: registered outputs, colour taken from VRAM only inside the window.
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      rgb         <= 16'h0000;
    end else begin
      de          <= vis1;
      hsync       <= hs1;
      vsync       <= vs1;
      frame_start <= fs1;
      rgb         <= (win1 && !blank1) ? vout : 16'h0000;
    end
  end

endmodule

// File: doc/video_scanout.md
VIDEO_SCANOUT -- requirements
Module: video_scanout

Interface
REQ-001 The module SHALL have parameter H_TOTAL, 800, pixel clocks per line.
REQ-002 The module SHALL have parameter V_TOTAL, 525, lines per frame.
REQ-003 The module SHALL have parameter X_OFF, 64, first visible column of the image window.
REQ-004 The module SHALL have port vclk  input  1  pixel clock, all logic on its rising edge.
REQ-005 The module SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 The module SHALL have port blank  input  1  force black pixels while high.
REQ-007 The module SHALL have port vaddr  output  14  VRAM word address to memory video port.
REQ-008 The module SHALL have port vout  input  16  VRAM read data, valid one vclk after vaddr is sampled.
REQ-009 The module SHALL have port hsync  output  1  horizontal sync, active low.
REQ-010 The module SHALL have port vsync  output  1  vertical sync, active low.
REQ-011 The module SHALL have port de  output  1  display enable, high for visible pixels.
REQ-012 The module SHALL have port rgb  output  16  pixel colour, RGB565.
REQ-013 The module SHALL have port frame_start  output  1  one-cycle pulse aligned with the first pixel of a frame.

Function
REQ-014 Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) SHALL advance every vclk; h wraps to 0 at H_TOTAL-1, incrementing v_cnt; v wraps to 0 when h and v are both at maximum.
REQ-015 Visible region SHALL be h_cnt<640 and v_cnt<480; hsync low for 656<=h_cnt<752; vsync low for 490<=v_cnt<492.
REQ-016 Image window SHALL be X_OFF<=h_cnt<X_OFF+512 and v_cnt<480; 4x scaling: col=(h_cnt-X_OFF)>>2 (0..127), row=v_cnt>>2 (0..119).
REQ-017 vaddr SHALL equal {row[6:0],col[6:0]} inside the window and 0 outside, decoded from counter registers only (no input-dependent logic).
REQ-018 Pipeline SHALL be: stage 0 counters/vaddr; stage 1 memory returns vout; stage 2 registered outputs; hsync, vsync, de, rgb, frame_start SHALL all appear 2 vclk after the counter state that produced them, mutually aligned.
REQ-019 rgb SHALL be vout captured when the delayed in-window flag is set and blank (sampled at stage 1) is low; otherwise 16'h0000.
REQ-020 Visible pixels outside the window (h 0..63 and 576..639) SHALL output rgb=0 with de=1.
REQ-021 frame_start SHALL be high for exactly one vclk, in the output cycle corresponding to h_cnt=0,v_cnt=0.
REQ-022 blank SHALL affect rgb only; timing, sync and vaddr SHALL be unaffected.
REQ-023 Address range SHALL never exceed 15359 (row 119, col 127).

Reset
REQ-024 While rst_n is low, asynchronously: h_cnt=0, v_cnt=0, pipeline flags cleared, hsync=1, vsync=1, de=0, rgb=0, frame_start=0; vaddr=0.
REQ-025 Release of rst_n mid-frame SHALL restart at h_cnt=0,v_cnt=0; first de=1 appears 2 vclk after the first post-reset edge; frame_start SHALL pulse at that point.
REQ-026 Reset asserted mid-line SHALL clear outputs within the same cycle, without waiting for a clock edge.

Verification
REQ-027 Free-run one frame -> exactly 420000 clocks between frame_start pulses; 480 lines with 640 de cycles; hsync low 96 clocks/line; vsync low 2 lines.
REQ-028 Memory model with 1-cycle latency, word N = N -> output cycle for h=64,v=0 rgb=0; h=68 -> 1; h=575,v=479 -> 15359; h=576 -> 0 with de=1.
REQ-029 vaddr monitor across a frame -> values only 0..15359; each address presented on 4 consecutive clocks on each of 4 lines.
REQ-030 blank=1 for line 10 only -> rgb=0 on that line, de/hsync unchanged, line 11 pixels correct.
REQ-031 Assert rst_n low at h=300,v=200 for 3 clocks -> outputs reset immediately; after release, frame_start 2 clocks later, full-length frame follows.
REQ-032 Alignment check -> rising edge of de and first non-zero rgb occur 2 clocks after counters enter the visible or window region, never earlier.
